// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the receiver-side handshake and the CPU-side FIFO/status signals
// of the UART receive buffer.
//
// Signals
//   rx_data      receiver -> fifo  received byte, valid while rx_flag=1
//   rx_flag      receiver -> fifo  receiver holds a completed byte (level)
//   clr_rx_flag  fifo -> receiver  active-low ack, low for one cycle
//   rd_en        cpu -> fifo       pop strobe, one pulse per byte
//   ovr_clr      cpu -> fifo       clears the sticky overrun flag
//   rd_data      fifo -> cpu       head-of-FIFO byte (show-ahead)
//   empty/full   fifo -> cpu       occupancy flags
//   count        fifo -> cpu       number of stored bytes, 0..DEPTH
//   overrun      fifo -> cpu       sticky: a byte was dropped while full
//
// Modports
//   slave   the FIFO itself
//   master  the environment (receiver + CPU side)
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
  parameter int NBIT     = 8,
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = $clog2(DEPTH)
);
  logic [NBIT-1:0]   rx_data;
  logic              rx_flag;
  logic              clr_rx_flag;
  logic              rd_en;
  logic              ovr_clr;
  logic [NBIT-1:0]   rd_data;
  logic              empty;
  logic              full;
  logic [PTR_BITS:0] count;
  logic              overrun;

  modport slave (
    input  rx_data, rx_flag, rd_en, ovr_clr,
    output clr_rx_flag, rd_data, empty, full, count, overrun
  );

  modport master (
    output rx_data, rx_flag, rd_en, ovr_clr,
    input  clr_rx_flag, rd_data, empty, full, count, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Consumer stage behind the UART receiver. Captures each completed byte,
// acknowledges it with a one-cycle active-low clr_rx_flag pulse, and buffers
// it in a DEPTH-entry FIFO that the CPU drains through memory-mapped
// data/status registers.
//
// Ports
//   clk    in  system clock, all logic on the rising edge
//   reset  in  asynchronous, active-high reset
//   bus    uart_rx_fifo_if.slave  receiver handshake + CPU FIFO interface
//
// Parameters
//   NBIT      data width, must match the receiver
//   DEPTH     FIFO entries, power of two, >= 2
//   PTR_BITS  pointer width; count is PTR_BITS+1 bits
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int NBIT     = 8,
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);

  localparam logic [PTR_BITS:0]   FULL_COUNT = (PTR_BITS + 1)'(DEPTH);
  localparam logic [PTR_BITS:0]   COUNT_ONE  = (PTR_BITS + 1)'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE    = PTR_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT
  } captureState_t;

  captureState_t       r_state;
  logic                r_clrRxFlag;
  logic [NBIT-1:0]     r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wrPtr;
  logic [PTR_BITS-1:0] r_rdPtr;
  logic [PTR_BITS:0]   r_count;
  logic                r_overrun;

  logic w_isFull;
  logic w_isEmpty;
  logic w_capture;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Push/pop decisions for this cycle. A pop in the same cycle frees a slot,
  // so a capture while full is only dropped when no pop accompanies it.
  // A pop request while empty is simply ignored.
  always_comb begin
    w_isFull  = (r_count == FULL_COUNT);
    w_isEmpty = (r_count == '0);
    w_capture = (r_state == S_IDLE) && bus.rx_flag;
    w_pop     = bus.rd_en && !w_isEmpty;
    w_push    = w_capture && (!w_isFull || w_pop);
    w_drop    = w_capture && w_isFull && !w_pop;
  end

  // Capture handshake. The ack is low only during ACK; WAIT then holds off
  // until the receiver has lowered rx_flag, which it does one cycle after
  // seeing the ack, so the same byte is never captured twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_clrRxFlag <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clrRxFlag <= 1'b1;
          if (bus.rx_flag) begin
            r_state     <= S_ACK;
            r_clrRxFlag <= 1'b0;
          end
        end
        S_ACK: begin
          r_state     <= S_WAIT;
          r_clrRxFlag <= 1'b1;
        end
        S_WAIT: begin
          r_clrRxFlag <= 1'b1;
          if (!bus.rx_flag) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_clrRxFlag <= 1'b1;
        end
      endcase
    end
  end

  // Storage and pointers. Storage is cleared on reset so the show-ahead
  // output reads zero out of reset; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= bus.rx_data;
        r_wrPtr        <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (bus.ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.clr_rx_flag = r_clrRxFlag;
  assign bus.rd_data     = r_mem[r_rdPtr];
  assign bus.empty       = w_isEmpty;
  assign bus.full        = w_isFull;
  assign bus.count       = r_count;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. The reference model treats the FIFO
// as a queue: every new byte offered by the receiver (a rising rx_flag) is
// appended if there is room after any same-cycle pop, otherwise it is
// dropped and overrun is raised. The ack must be low exactly in the cycle
// after a capture.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int NBIT  = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;

  uart_rx_fifo_if #(.NBIT(NBIT), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.NBIT(NBIT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  int totalChecks  = 0;
  int passedChecks = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       mOvr     = 1'b0;
  logic       mClrExp  = 1'b1;
  logic       prevFlag = 1'b0;

  typedef struct {
    logic       flag;
    logic [7:0] data;
    logic       rd;
    logic       oc;
    int         expCount;
    logic [7:0] expHead;
    logic       expOvr;
    logic       expClr;
  } vecT;

  vecT vecs[12];

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) begin
      passedChecks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the clock edge,
  // and return just after the edge
  task automatic applyStimulus(input logic flag, input logic [7:0] data, input logic rd, input logic oc);
    logic cap;
    logic popOk;
    logic drop;
    @(negedge clk);
    bus.rx_flag = flag;
    bus.rx_data = data;
    bus.rd_en   = rd;
    bus.ovr_clr = oc;
    @(posedge clk);
    cap   = flag && !prevFlag;
    popOk = rd && (mq.size() != 0);
    drop  = 1'b0;
    if (popOk) void'(mq.pop_front());
    if (cap) begin
      if (mq.size() < DEPTH) mq.push_back(data);
      else drop = 1'b1;
    end
    if (drop) mOvr = 1'b1;
    else if (oc) mOvr = 1'b0;
    mClrExp  = !cap;
    prevFlag = flag;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " count"},       32'(bus.count),       32'(mq.size()));
    checkVal({tag, " empty"},       32'(bus.empty),       32'(mq.size() == 0));
    checkVal({tag, " full"},        32'(bus.full),        32'(mq.size() == DEPTH));
    checkVal({tag, " overrun"},     32'(bus.overrun),     32'(mOvr));
    checkVal({tag, " clr_rx_flag"}, 32'(bus.clr_rx_flag), 32'(mClrExp));
    if (mq.size() != 0) checkVal({tag, " rd_data"}, 32'(bus.rd_data), 32'(mq[0]));
  endtask

  // Receiver-style delivery: flag high through the ack cycle, then low
  task automatic sendByte(input string tag, input logic [7:0] data, input logic rdFirst, input logic ocFirst);
    applyStimulus(1'b1, data, rdFirst, ocFirst);
    checkOutput({tag, " capture"});
    applyStimulus(1'b1, data, 1'b0, 1'b0);
    checkOutput({tag, " ack"});
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput({tag, " release"});
  endtask

  task automatic popByte(input string tag, input logic [7:0] expected);
    checkVal({tag, " head"}, 32'(bus.rd_data), 32'(expected));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput({tag, " pop"});
  endtask

  task automatic modelReset();
    mq.delete();
    mOvr     = 1'b0;
    mClrExp  = 1'b1;
    prevFlag = 1'b0;
  endtask

  initial begin
    // Single-byte handshake and pop-while-empty sequence
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1, 8'h3C, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1, 8'h5A, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 8'h5A, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h5A, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1};

    bus.rx_flag = 1'b0;
    bus.rx_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.ovr_clr = 1'b0;
    reset       = 1'b1;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset count",       32'(bus.count),       32'd0);
    checkVal("reset empty",       32'(bus.empty),       32'd1);
    checkVal("reset full",        32'(bus.full),        32'd0);
    checkVal("reset overrun",     32'(bus.overrun),     32'd0);
    checkVal("reset clr_rx_flag", 32'(bus.clr_rx_flag), 32'd1);
    checkVal("reset rd_data",     32'(bus.rd_data),     32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven single-byte sequence
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].flag, vecs[i].data, vecs[i].rd, vecs[i].oc);
      checkVal($sformatf("vec%0d count", i),   32'(bus.count),       32'(vecs[i].expCount));
      checkVal($sformatf("vec%0d empty", i),   32'(bus.empty),       32'(vecs[i].expCount == 0));
      checkVal($sformatf("vec%0d overrun", i), 32'(bus.overrun),     32'(vecs[i].expOvr));
      checkVal($sformatf("vec%0d clr", i),     32'(bus.clr_rx_flag), 32'(vecs[i].expClr));
      if (vecs[i].expCount != 0)
        checkVal($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(vecs[i].expHead));
    end

    // Fill, wrap and ordering
    for (int i = 1; i <= 8; i++) sendByte("fill", 8'(i), 1'b0, 1'b0);
    checkVal("fill full",  32'(bus.full),  32'd1);
    checkVal("fill count", 32'(bus.count), 32'd8);
    for (int i = 1; i <= 3; i++) popByte("wrap pop", 8'(i));
    for (int i = 9; i <= 11; i++) sendByte("wrap push", 8'(i), 1'b0, 1'b0);
    for (int i = 4; i <= 11; i++) popByte("wrap drain", 8'(i));
    checkVal("wrap empty", 32'(bus.empty), 32'd1);

    // Overrun: dropped byte still acked, clear, then set-wins-over-clear
    for (int i = 0; i < 8; i++) sendByte("ovr fill", 8'(8'h10 + i), 1'b0, 1'b0);
    sendByte("ovr drop", 8'hFF, 1'b0, 1'b0);
    checkVal("ovr set",   32'(bus.overrun), 32'd1);
    checkVal("ovr count", 32'(bus.count),   32'd8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovr clear");
    checkVal("ovr cleared", 32'(bus.overrun), 32'd0);
    sendByte("ovr set-wins", 8'hEE, 1'b0, 1'b1);
    checkVal("ovr set-wins flag", 32'(bus.overrun), 32'd1);

    // Reset asserted while the ack is low; byte still flagged afterwards
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    checkVal("mid-ack clr low", 32'(bus.clr_rx_flag), 32'd0);
    #1 reset = 1'b1;
    #1;
    checkVal("async reset clr_rx_flag", 32'(bus.clr_rx_flag), 32'd1);
    checkVal("async reset count",       32'(bus.count),       32'd0);
    checkVal("async reset empty",       32'(bus.empty),       32'd1);
    checkVal("async reset overrun",     32'(bus.overrun),     32'd0);
    modelReset();
    #1 reset = 1'b0;
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    checkOutput("post-reset capture");
    checkVal("post-reset rd_data", 32'(bus.rd_data), 32'hC3);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    checkOutput("post-reset ack");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("post-reset release");

    // Push while full with a same-cycle pop
    for (int i = 0; i < 7; i++) sendByte("sim fill", 8'(8'h60 + i), 1'b0, 1'b0);
    sendByte("sim full push+pop", 8'h77, 1'b1, 1'b0);
    checkVal("sim no overrun", 32'(bus.overrun), 32'd0);
    checkVal("sim count",      32'(bus.count),   32'd8);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("sim drain");
    end
    checkVal("sim tail", 32'(bus.rd_data), 32'h77);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("sim last pop");
    sendByte("sim empty push+pop", 8'h42, 1'b1, 1'b0);
    checkVal("sim empty count", 32'(bus.count), 32'd1);

    // Flag held high well past the ack: exactly one push
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("held capture");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
      checkOutput("held high");
    end
    checkVal("held count", 32'(bus.count), 32'd2);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("held release");
    sendByte("held next", 8'h9A, 1'b0, 1'b0);
    checkVal("held next count", 32'(bus.count), 32'd3);

    // Randomised traffic: a filling phase followed by a draining phase
    for (int b = 0; b < 120; b++) begin
      logic [7:0] d;
      int hi;
      int lo;
      int rdPct;
      d     = 8'($urandom);
      hi    = $urandom_range(2, 4);
      lo    = $urandom_range(1, 3);
      rdPct = (b < 60) ? 12 : 45;
      for (int c = 0; c < hi + lo; c++) begin
        applyStimulus((c < hi) ? 1'b1 : 1'b0, d,
                      ($urandom_range(0, 99) < rdPct) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
        checkOutput("random");
      end
    end

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
